// File: rtl/bus_fifo_port.sv
// bus_fifo_port: CPU bus slave mapping a 4-register window onto TX/RX stream FIFOs with a level irq.
// Define BUS_FIFO_PORT_OVF_CNT_EN to add the saturating dropped-TX-write counter at offset 3.
module bus_fifo_port #(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] address_bus,
   inout  wire  [15:0] data_bus,
   input  logic        r,
   input  logic        w,
   output logic        irq,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW = DEPTH_LOG2 + 1;
   logic [15:0] tx_mem_q [DEPTH];
   logic [15:0] tx_mem_d [DEPTH];
   logic [15:0] rx_mem_q [DEPTH];
   logic [15:0] rx_mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [1:0] ctrl_q, ctrl_d, off;
   logic ovf_q, ovf_d, irq_q, irq_d;
   logic sel, rd, wr, tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop, drop;
   logic [15:0] rdata, ovfcnt;
   assign sel      = address_bus[15:2] == BASE_ADDR[15:2];
   assign off      = address_bus[1:0];
   assign rd       = reset_n & r & sel & ~w;
   assign wr       = w & sel;
   assign tx_full  = tx_cnt_q == CW'(DEPTH);
   assign tx_empty = tx_cnt_q == '0;
   assign rx_full  = rx_cnt_q == CW'(DEPTH);
   assign rx_empty = rx_cnt_q == '0;
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_mem_q[tx_rp_q];
   assign rx_ready = reset_n & ~rx_full;
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_push  = wr & (off == 2'd0) & (~tx_full | tx_pop);
   assign drop     = wr & (off == 2'd0) & tx_full & ~tx_pop;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = rd & (off == 2'd0) & ~rx_empty;
   assign irq      = irq_q;
   assign rdata = (off == 2'd0) ? (rx_empty ? 16'h0000 : rx_mem_q[rx_rp_q]) :
                  (off == 2'd1) ? {4'(tx_cnt_q), 4'(rx_cnt_q), 3'b000, ovf_q, tx_full, tx_empty, rx_full, ~rx_empty} :
                  (off == 2'd2) ? {14'b0, ctrl_q} : ovfcnt;
   assign data_bus = rd ? rdata : 'z;
   always_comb begin
      tx_mem_d = tx_mem_q;
      rx_mem_d = rx_mem_q;
      if (tx_push) tx_mem_d[tx_wp_q] = data_bus;
      if (rx_push) rx_mem_d[rx_wp_q] = rx_data;
      tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
      tx_rp_d  = tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
      rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
      rx_rp_d  = rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      ctrl_d   = (wr && off == 2'd2) ? data_bus[1:0] : ctrl_q;
      ovf_d    = drop | (ovf_q & ~(wr && off == 2'd1 && data_bus[4]));
      irq_d    = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
   end
   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         ctrl_q   <= '0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
      end
   end
`ifdef BUS_FIFO_PORT_OVF_CNT_EN
   logic [15:0] ovfcnt_q, ovfcnt_d;
   // Clearing by a write to offset 3 takes priority over a drop on the same edge.
   assign ovfcnt_d = (wr && off == 2'd3) ? 16'h0000 : (drop && ~&ovfcnt_q) ? ovfcnt_q + 16'd1 : ovfcnt_q;
   assign ovfcnt   = ovfcnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovfcnt_q <= '0;
      else ovfcnt_q <= ovfcnt_d;
   end
`else
   assign ovfcnt = 16'h0000;
`endif
endmodule

// File: tb/tb_bus_fifo_port.sv
// tb_bus_fifo_port: directed and randomized checks of bus_fifo_port against a queue-based model.
module tb_bus_fifo_port;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset_n = 1'b0, r = 1'b0, w = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
   logic [15:0] address_bus = '0, rx_data = '0, bus_drv = '0;
   logic bus_oe = 1'b0;
   logic irq, tx_valid, rx_ready;
   logic [15:0] tx_data;
   wire [15:0] data_bus;
   int checks = 0, failures = 0;
   logic [15:0] txq[$], rxq[$];
   logic [1:0] m_ctrl;
   logic m_ovf, m_irq;
   logic [15:0] m_cnt;
   logic [15:0] o_bus, o_txd, e_bus, e_txd;
   logic o_txv, o_rxr, o_irq, e_txv, e_rxr, e_irq;

   assign data_bus = bus_oe ? bus_drv : 'z;
   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (data_bus[g]);
   end

   bus_fifo_port #(.BASE_ADDR(16'hFF00), .DEPTH_LOG2(2)) dut (
      .clk(clk), .reset_n(reset_n), .address_bus(address_bus), .data_bus(data_bus),
      .r(r), .w(w), .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_ctrl = 2'b00;
      m_ovf = 1'b0;
      m_irq = 1'b0;
      m_cnt = 16'h0000;
   endtask

   function automatic logic [15:0] m_read(input logic [1:0] o);
      int tn = txq.size(), rn = rxq.size();
      case (o)
         2'd0: return (rn > 0) ? rxq[0] : 16'h0000;
         2'd1: return {4'(tn), 4'(rn), 3'b000, m_ovf, tn == DEPTH, tn == 0, rn == DEPTH, rn != 0};
         2'd2: return {14'b0, m_ctrl};
`ifdef BUS_FIFO_PORT_OVF_CNT_EN
         default: return m_cnt;
`else
         default: return 16'h0000;
`endif
      endcase
   endfunction

   // One bus cycle: op bit0 = read strobe, bit1 = write strobe. Called at posedge+1.
   task automatic step(input int op, input logic [15:0] a, input logic [15:0] wd,
                       input logic rv, input logic [15:0] rdat, input logic tr);
      logic sel, rd, wrs, tx_pop, rx_push, acc, nirq;
      address_bus = a;
      r = op[0];
      w = op[1];
      bus_oe = op[1];
      bus_drv = wd;
      rx_valid = rv;
      rx_data = rdat;
      tx_ready = tr;
      @(negedge clk);
      o_bus = data_bus;
      o_txv = tx_valid;
      o_txd = tx_data;
      o_rxr = rx_ready;
      o_irq = irq;
      sel = a[15:2] == 14'h3FC0;
      rd = op[0] && !op[1] && sel;
      wrs = op[1] && sel;
      e_bus = op[1] ? wd : rd ? m_read(a[1:0]) : 16'hFFFF;
      e_txv = txq.size() > 0;
      e_txd = e_txv ? txq[0] : 16'h0000;
      e_rxr = rxq.size() < DEPTH;
      e_irq = m_irq;
      tx_pop = e_txv && tr;
      rx_push = rv && e_rxr;
      nirq = (m_ctrl[0] && rxq.size() > 0) || (m_ctrl[1] && txq.size() == 0);
      acc = txq.size() < DEPTH || tx_pop;
      if (tx_pop) void'(txq.pop_front());
      if (wrs && a[1:0] == 2'd0) begin
         if (acc) txq.push_back(wd);
         else begin
            m_ovf = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt++;
         end
      end
      if (rd && a[1:0] == 2'd0 && rxq.size() > 0) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(rdat);
      if (wrs && a[1:0] == 2'd1 && wd[4]) m_ovf = 1'b0;
      if (wrs && a[1:0] == 2'd2) m_ctrl = wd[1:0];
      if (wrs && a[1:0] == 2'd3) m_cnt = 16'h0000;
      m_irq = nirq;
      @(posedge clk);
      #1;
      r = 1'b0;
      w = 1'b0;
      bus_oe = 1'b0;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
      step(2, a, d, 1'b0, 16'h0, 1'b0);
   endtask
   task automatic cpu_rd(input logic [15:0] a);
      step(1, a, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask
   task automatic idle(input logic tr);
      step(0, 16'h0000, 16'h0, 1'b0, 16'h0, tr);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      // Build up state, then reset in the middle of a selected read
      cpu_wr(16'hFF02, 16'h0002);
      idle(1'b0);
      cpu_wr(16'hFF00, 16'hAAAA);
      chk("pre_rst_irq", 16'(o_irq), 16'h1);
      address_bus = 16'hFF01;
      r = 1'b1;
      #2;
      chk("pre_rst_txv", 16'(tx_valid), 16'h1);
      reset_n = 1'b0;
      #1;
      chk("rst_irq", 16'(irq), 16'h0);
      chk("rst_txv", 16'(tx_valid), 16'h0);
      chk("rst_rxr", 16'(rx_ready), 16'h0);
      chk("rst_bus_z", data_bus, 16'hFFFF);
      r = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      cpu_rd(16'hFF01);
      chk("rst_status", o_bus, 16'h0004);
      chk("rst_rxr_up", 16'(o_rxr), 16'h1);
      // TX path
      cpu_wr(16'hFF00, 16'h1234);
      cpu_wr(16'hFF00, 16'h5678);
      cpu_rd(16'hFF01);
      chk("tx_status", o_bus, 16'h2000);
      chk("tx_valid", 16'(o_txv), 16'h1);
      chk("tx_head", o_txd, 16'h1234);
      idle(1'b1);
      chk("tx_pop0", o_txd, 16'h1234);
      idle(1'b1);
      chk("tx_pop1", o_txd, 16'h5678);
      idle(1'b0);
      chk("tx_drained", 16'(o_txv), 16'h0);
      // TX overflow
      for (int i = 1; i <= 4; i++) cpu_wr(16'hFF00, 16'(16'h1111 * i));
      cpu_wr(16'hFF00, 16'hDEAD);
      cpu_rd(16'hFF01);
      chk("ovf_status", o_bus, 16'h4018);
      cpu_wr(16'hFF01, 16'h0010);
      cpu_rd(16'hFF01);
      chk("ovf_clear", o_bus, 16'h4008);
      cpu_wr(16'hFF00, 16'hBEEF);
      cpu_rd(16'hFF03);
`ifdef BUS_FIFO_PORT_OVF_CNT_EN
      chk("ovfcnt", o_bus, 16'h0002);
`else
      chk("ovfcnt", o_bus, 16'h0000);
`endif
      cpu_wr(16'hFF03, 16'hFFFF);
      cpu_rd(16'hFF03);
      chk("ovfcnt_clr", o_bus, 16'h0000);
      // Full TX with same-edge CPU write and stream pop
      cpu_wr(16'hFF01, 16'h0010);
      step(2, 16'hFF00, 16'h5555, 1'b0, 16'h0, 1'b1);
      cpu_rd(16'hFF01);
      chk("same_edge", o_bus, 16'h4008);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         chk("drain", o_txd, 16'(16'h1111 * (i + 2)));
      end
      idle(1'b0);
      chk("drain_empty", 16'(o_txv), 16'h0);
      // RX path
      step(0, 16'h0, 16'h0, 1'b1, 16'h00A1, 1'b0);
      step(0, 16'h0, 16'h0, 1'b1, 16'h00A2, 1'b0);
      cpu_rd(16'hFF01);
      chk("rx_status", o_bus, 16'h0205);
      cpu_rd(16'hFF00);
      chk("rx_rd0", o_bus, 16'h00A1);
      cpu_rd(16'hFF00);
      chk("rx_rd1", o_bus, 16'h00A2);
      cpu_rd(16'hFF00);
      chk("rx_rd_empty", o_bus, 16'h0000);
      cpu_rd(16'hFF01);
      chk("rx_status_empty", o_bus, 16'h0004);
      // IRQ timing
      cpu_wr(16'hFF02, 16'h0001);
      step(0, 16'h0, 16'h0, 1'b1, 16'h00B1, 1'b0);
      chk("irq_push_cyc", 16'(o_irq), 16'h0);
      idle(1'b0);
      chk("irq_after_push", 16'(o_irq), 16'h0);
      idle(1'b0);
      chk("irq_set", 16'(o_irq), 16'h1);
      cpu_rd(16'hFF00);
      chk("irq_pop_data", o_bus, 16'h00B1);
      idle(1'b0);
      chk("irq_after_pop", 16'(o_irq), 16'h1);
      idle(1'b0);
      chk("irq_clear", 16'(o_irq), 16'h0);
      cpu_wr(16'hFF02, 16'h0002);
      idle(1'b0);
      chk("irq_tx_lag", 16'(o_irq), 16'h0);
      idle(1'b0);
      chk("irq_tx_empty", 16'(o_irq), 16'h1);
      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         int k = $urandom_range(0, 9);
         int op = (k < 4) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3;
         logic [15:0] a = ($urandom_range(0, 7) < 6) ? 16'hFF00 : 16'hFE00;
         a[1:0] = 2'($urandom_range(0, 3));
         step(op, a, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2) == 0);
         chk("rnd_bus", o_bus, e_bus);
         chk("rnd_txv", 16'(o_txv), 16'(e_txv));
         if (e_txv) chk("rnd_txd", o_txd, e_txd);
         chk("rnd_rxr", 16'(o_rxr), 16'(e_rxr));
         chk("rnd_irq", 16'(o_irq), 16'(e_irq));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
